// File: rtl/time_set_controller.sv
// time_set_controller: owns the mm:ss time registers and advances them once per
// second in RUN. Three debounced pushbuttons cycle the mode and edit the selected
// field, and a blink mask flashes the field being edited. All logic runs on
// CLK100MHZ using clock enables only.
module time_set_controller #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic       CLK100MHZ,
    input  logic       R,
    input  logic       BTN_MODE,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] MODE,
    output logic [3:0] BLANK,
    output logic       TICK
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(DB_CYCLES);
    localparam int unsigned BW = $clog2(BLINK_DIV);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    // Button lanes inside the 3-bit vectors
    localparam int BI_MODE = 0;
    localparam int BI_UP   = 1;
    localparam int BI_DN   = 2;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_MIN = 2'b01,
        ST_SET_SEC = 2'b10
    } state_e;

    // Modulo-60 step helpers shared by RUN counting and the set modes
    function automatic logic [5:0] inc60(input logic [5:0] v);
        if (v >= 6'd59) begin
            inc60 = 6'd0;
        end else begin
            inc60 = v + 6'd1;
        end
    endfunction

    function automatic logic [5:0] dec60(input logic [5:0] v);
        if (v == 6'd0) begin
            dec60 = 6'd59;
        end else begin
            dec60 = v - 6'd1;
        end
    endfunction

    // Button path state
    logic [2:0]    btn_raw_s;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    db_q, db_d;
    logic [2:0]    db_prev_q;
    logic [DW-1:0] db_cnt_q [3];
    logic [DW-1:0] db_cnt_d [3];
    logic [2:0]    press_s;

    // Core state
    state_e        state_q, state_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [3:0]    blank_q, blank_d;
    logic          tick_q, tick_d;

    logic          edit_up_s, edit_dn_s, any_edit_s;

    assign btn_raw_s = {BTN_DOWN, BTN_UP, BTN_MODE};

    // A press is the cycle after the debounced level rose
    assign press_s    = db_q & ~db_prev_q;
    assign edit_up_s  = press_s[BI_UP] & ~press_s[BI_DN];
    assign edit_dn_s  = press_s[BI_DN] & ~press_s[BI_UP];
    assign any_edit_s = press_s[BI_UP] | press_s[BI_DN];

    // Debounce: count while the synced level differs, flip on the DB_CYCLES-th such cycle
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = {DW{1'b0}};
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i]     = ~db_q[i];
                    db_cnt_d[i] = {DW{1'b0}};
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
            end else begin
                db_cnt_d[i] = {DW{1'b0}};
            end
        end
    end

    // Synchronizer, debounce counters and debounced levels
    always_ff @(posedge CLK100MHZ or negedge R) begin
        if (!R) begin
            sync1_q   <= 3'b000;
            sync2_q   <= 3'b000;
            db_q      <= 3'b000;
            db_prev_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= {DW{1'b0}};
            end
        end else begin
            sync1_q   <= btn_raw_s;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // Next-state: mode FSM, time counting/editing, blink timing and blank mask
    always_comb begin
        state_d     = state_q;
        min_d       = min_q;
        sec_d       = sec_q;
        presc_d     = presc_q;
        tick_d      = 1'b0;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        blank_d     = 4'b0000;

        // Edits follow the current state; the MODE transition happens alongside
        case (state_q)
            ST_RUN: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = {PW{1'b0}};
                    tick_d  = 1'b1;
                    if (sec_q >= 6'd59) begin
                        sec_d = 6'd0;
                        min_d = inc60(min_q);
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                if (press_s[BI_MODE]) begin
                    state_d = ST_SET_MIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SET_MIN: begin
                presc_d = {PW{1'b0}};
                if (edit_up_s) begin
                    min_d = inc60(min_q);
                end else if (edit_dn_s) begin
                    min_d = dec60(min_q);
                end else begin
                    min_d = min_q;
                end
                if (press_s[BI_MODE]) begin
                    state_d = ST_SET_SEC;
                end else begin
                    state_d = ST_SET_MIN;
                end
            end
            ST_SET_SEC: begin
                presc_d = {PW{1'b0}};
                if (edit_up_s) begin
                    sec_d = inc60(sec_q);
                end else if (edit_dn_s) begin
                    sec_d = dec60(sec_q);
                end else begin
                    sec_d = sec_q;
                end
                if (press_s[BI_MODE]) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_SET_SEC;
                end
            end
            default: begin
                state_d = ST_RUN;
                presc_d = {PW{1'b0}};
            end
        endcase

        // Blink restarts visible on any mode change or edit, free-runs only while setting
        if (press_s[BI_MODE]) begin
            blink_cnt_d = {BW{1'b0}};
            phase_d     = 1'b1;
        end else if (state_q != ST_RUN && any_edit_s) begin
            blink_cnt_d = {BW{1'b0}};
            phase_d     = 1'b1;
        end else if (state_q != ST_RUN) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = {BW{1'b0}};
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end else begin
            blink_cnt_d = {BW{1'b0}};
        end

        // Mask derived from next-state values so it lines up with MODE
        case (state_d)
            ST_SET_MIN: blank_d = {~phase_d, ~phase_d, 2'b00};
            ST_SET_SEC: blank_d = {2'b00, ~phase_d, ~phase_d};
            default:    blank_d = 4'b0000;
        endcase
    end

    // Core registers; every output comes straight from one of these
    always_ff @(posedge CLK100MHZ or negedge R) begin
        if (!R) begin
            state_q     <= ST_RUN;
            min_q       <= 6'd0;
            sec_q       <= 6'd0;
            presc_q     <= {PW{1'b0}};
            blink_cnt_q <= {BW{1'b0}};
            phase_q     <= 1'b0;
            blank_q     <= 4'b0000;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            blank_q     <= blank_d;
            tick_q      <= tick_d;
        end
    end

    assign minutes = min_q;
    assign seconds = sec_q;
    assign MODE    = state_q;
    assign BLANK   = blank_q;
    assign TICK    = tick_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller with small divider values.
module tb_time_set_controller;
    localparam int unsigned TICK_DIV  = 10;
    localparam int unsigned DB_CYCLES = 4;
    localparam int unsigned BLINK_DIV = 8;

    localparam logic [2:0] B_NONE = 3'b000;
    localparam logic [2:0] B_MODE = 3'b001;
    localparam logic [2:0] B_UP   = 3'b010;
    localparam logic [2:0] B_DN   = 3'b100;

    logic       clk;
    logic       r_n;
    logic       btn_mode, btn_up, btn_dn;
    logic [5:0] minutes_s, seconds_s;
    logic [1:0] mode_s;
    logic [3:0] blank_s;
    logic       tick_s;

    time_set_controller #(
        .TICK_DIV (TICK_DIV),
        .DB_CYCLES(DB_CYCLES),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .CLK100MHZ(clk),
        .R        (r_n),
        .BTN_MODE (btn_mode),
        .BTN_UP   (btn_up),
        .BTN_DOWN (btn_dn),
        .minutes  (minutes_s),
        .seconds  (seconds_s),
        .MODE     (mode_s),
        .BLANK    (blank_s),
        .TICK     (tick_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic [5:0] mn;
        logic [5:0] sc;
        logic [1:0] md;
        logic [3:0] bl;
        logic       chk_bl;
        logic       tk;
    } exp_t;

    typedef struct packed {
        logic [2:0] btn;
        logic [5:0] mn;
        logic [5:0] sc;
        logic [1:0] md;
        logic [3:0] bl;
    } vec_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic sb_push(input string nm, input logic [5:0] mn, input logic [5:0] sc,
                           input logic [1:0] md, input logic [3:0] bl, input logic chk_bl,
                           input logic tk);
        exp_t e;
        e.name = nm; e.mn = mn; e.sc = sc; e.md = md; e.bl = bl; e.chk_bl = chk_bl; e.tk = tk;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        logic ok;
        total_cnt++;
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard: no expected record queued");
        end else begin
            e  = sb_q.pop_front();
            ok = (minutes_s == e.mn) && (seconds_s == e.sc) && (mode_s == e.md) &&
                 (tick_s == e.tk) && (!e.chk_bl || (blank_s == e.bl));
            if (ok) begin
                pass_cnt++;
            end else begin
                $display("FAIL %s: got %0d:%0d mode=%b blank=%b tick=%b, want %0d:%0d mode=%b blank=%b(chk=%b) tick=%b",
                         e.name, minutes_s, seconds_s, mode_s, blank_s, tick_s,
                         e.mn, e.sc, e.md, e.bl, e.chk_bl, e.tk);
            end
        end
    endtask

    task automatic chk_val(input string nm, input int act, input int exp_v);
        total_cnt++;
        if (act == exp_v) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, want %0d", nm, act, exp_v);
        end
    endtask

    task automatic set_btn(input logic [2:0] m);
        btn_mode = m[0];
        btn_up   = m[1];
        btn_dn   = m[2];
    endtask

    // Hold the buttons 8 cycles, release, settle 8 cycles, then compare
    task automatic press_and_check(input string nm, input logic [2:0] m, input logic [5:0] mn,
                                   input logic [5:0] sc, input logic [1:0] md, input logic [3:0] bl);
        sb_push(nm, mn, sc, md, bl, 1'b1, 1'b0);
        set_btn(m);
        repeat (8) @(negedge clk);
        set_btn(B_NONE);
        repeat (8) @(negedge clk);
        sb_check();
    endtask

    vec_t       vecs [9];
    int         tick_cnt, first_tick, dbl_tick;
    logic       tick_prev;
    int         k, rbase;
    logic [3:0] exp_bl;
    logic [5:0] exp_mn;
    logic [1:0] exp_md;

    initial begin
        vecs[0] = '{B_MODE,        6'd0,  6'd0,  2'b01, 4'b1100};
        vecs[1] = '{B_DN,          6'd59, 6'd0,  2'b01, 4'b1100};
        vecs[2] = '{B_UP,          6'd0,  6'd0,  2'b01, 4'b1100};
        vecs[3] = '{B_DN | B_MODE, 6'd59, 6'd0,  2'b10, 4'b0011};
        vecs[4] = '{B_DN,          6'd59, 6'd59, 2'b10, 4'b0011};
        vecs[5] = '{B_UP,          6'd59, 6'd0,  2'b10, 4'b0011};
        vecs[6] = '{B_UP | B_DN,   6'd59, 6'd0,  2'b10, 4'b0011};
        vecs[7] = '{B_DN,          6'd59, 6'd59, 2'b10, 4'b0011};
        vecs[8] = '{B_MODE,        6'd59, 6'd59, 2'b00, 4'b0000};

        r_n = 1'b0;
        set_btn(B_NONE);
        repeat (3) @(negedge clk);
        sb_push("reset_state", 6'd0, 6'd0, 2'b00, 4'b0000, 1'b1, 1'b0);
        sb_check();

        // Free-running RUN for 6000 cycles
        r_n = 1'b1;
        tick_cnt = 0; first_tick = 0; dbl_tick = 0; tick_prev = 1'b0;
        for (int j = 1; j <= 6000; j++) begin
            @(negedge clk);
            if (tick_s) begin
                tick_cnt++;
                if (first_tick == 0) first_tick = j;
                if (tick_prev) dbl_tick++;
            end
            tick_prev = tick_s;
        end
        sb_push("run_6000", 6'd10, 6'd0, 2'b00, 4'b0000, 1'b1, 1'b1);
        sb_check();
        chk_val("tick_count", tick_cnt, 600);
        chk_val("first_tick_edge", first_tick, 10);
        chk_val("tick_width", dbl_tick, 0);

        // Fresh reset, then walk the edit table to 59:59 and back to RUN
        r_n = 1'b0;
        repeat (2) @(negedge clk);
        r_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            press_and_check($sformatf("vec%0d", i), vecs[i].btn, vecs[i].mn, vecs[i].sc,
                            vecs[i].md, vecs[i].bl);
        end

        // 59:59 rolls to 00:00 ten cycles after entering RUN, TICK for one cycle
        @(negedge clk);
        sb_push("rollover", 6'd0, 6'd0, 2'b00, 4'b0000, 1'b1, 1'b1);
        sb_check();
        @(negedge clk);
        sb_push("rollover_tick_low", 6'd0, 6'd0, 2'b00, 4'b0000, 1'b1, 1'b0);
        sb_check();
        press_and_check("run_up_ignored", B_UP, 6'd0, 6'd1, 2'b00, 4'b0000);
        press_and_check("to_set_min", B_MODE, 6'd0, 6'd2, 2'b01, 4'b1100);
        for (int i = 1; i <= 5; i++) begin
            press_and_check($sformatf("min_up%0d", i), B_UP, 6'(i), 6'd2, 2'b01, 4'b1100);
        end

        // Short glitch is rejected
        set_btn(B_UP);
        repeat (3) @(negedge clk);
        set_btn(B_NONE);
        repeat (16) @(negedge clk);
        sb_push("glitch", 6'd5, 6'd2, 2'b01, 4'b0000, 1'b0, 1'b0);
        sb_check();

        // Long hold: exactly one increment, visible on the 7th edge
        set_btn(B_UP);
        repeat (6) @(negedge clk);
        sb_push("hold_before", 6'd5, 6'd2, 2'b01, 4'b0000, 1'b0, 1'b0);
        sb_check();
        @(negedge clk);
        sb_push("hold_latency", 6'd6, 6'd2, 2'b01, 4'b0000, 1'b0, 1'b0);
        sb_check();
        repeat (13) @(negedge clk);
        set_btn(B_NONE);
        repeat (10) @(negedge clk);
        sb_push("hold_once", 6'd6, 6'd2, 2'b01, 4'b0000, 1'b0, 1'b0);
        sb_check();

        // Seconds editing with wrap and no carry
        press_and_check("to_set_sec", B_MODE, 6'd6, 6'd2, 2'b10, 4'b0011);
        press_and_check("sec_dn1", B_DN, 6'd6, 6'd1, 2'b10, 4'b0011);
        press_and_check("sec_dn2", B_DN, 6'd6, 6'd0, 2'b10, 4'b0011);
        press_and_check("sec_wrap", B_DN, 6'd6, 6'd59, 2'b10, 4'b0011);
        press_and_check("sec_updn", B_UP | B_DN, 6'd6, 6'd59, 2'b10, 4'b0011);
        press_and_check("back_run", B_MODE, 6'd6, 6'd59, 2'b00, 4'b0000);

        // Blink pattern in SET_MIN, restart on UP mid-blank
        set_btn(B_MODE);
        for (int j = 1; j <= 57; j++) begin
            @(negedge clk);
            k      = j - 7;
            exp_md = (j >= 7) ? 2'b01 : 2'b00;
            exp_mn = (j >= 35) ? 6'd8 : 6'd7;
            if (j < 7) begin
                exp_bl = 4'b0000;
            end else begin
                rbase  = (k >= 28) ? 28 : 0;
                exp_bl = ((((k - rbase) / 8) % 2) == 1) ? 4'b1100 : 4'b0000;
            end
            sb_push($sformatf("blink_j%0d", j), exp_mn, 6'd0, exp_md, exp_bl, 1'b1, (j == 1));
            sb_check();
            if (j == 8)  set_btn(B_NONE);
            if (j == 28) set_btn(B_UP);
            if (j == 36) set_btn(B_NONE);
        end
        press_and_check("blink_sec", B_MODE, 6'd8, 6'd0, 2'b10, 4'b0011);
        press_and_check("pre_rst_up1", B_UP, 6'd8, 6'd1, 2'b10, 4'b0011);
        press_and_check("pre_rst_up2", B_UP, 6'd8, 6'd2, 2'b10, 4'b0011);

        // Asynchronous reset between edges clears outputs before the next edge
        @(negedge clk);
        #2 r_n = 1'b0;
        #1;
        sb_push("async_reset", 6'd0, 6'd0, 2'b00, 4'b0000, 1'b1, 1'b0);
        sb_check();
        repeat (3) @(negedge clk);
        r_n = 1'b1;
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            if (j == 9) begin
                sb_push("post_rst_9", 6'd0, 6'd0, 2'b00, 4'b0000, 1'b1, 1'b0);
                sb_check();
            end
            if (j == 10) begin
                sb_push("post_rst_10", 6'd0, 6'd1, 2'b00, 4'b0000, 1'b1, 1'b1);
                sb_check();
            end
            if (j == 11) begin
                sb_push("post_rst_11", 6'd0, 6'd1, 2'b00, 4'b0000, 1'b1, 1'b0);
                sb_check();
            end
        end

        // MODE held through reset release is a fresh press after normal latency
        set_btn(B_MODE);
        @(negedge clk);
        #2 r_n = 1'b0;
        repeat (3) @(negedge clk);
        r_n = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            if (j == 6) begin
                sb_push("held_rst_6", 6'd0, 6'd0, 2'b00, 4'b0000, 1'b1, 1'b0);
                sb_check();
            end
            if (j == 7) begin
                sb_push("held_rst_7", 6'd0, 6'd0, 2'b01, 4'b0000, 1'b1, 1'b0);
                sb_check();
            end
        end
        set_btn(B_NONE);
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
